// File: rtl/ls_test_pkg.sv
// ----------------------------------------------------------------------------
// ls_test_pkg
// Shared definitions for the latch/shift test-chip stimulus path.
//   state_t         : frame sequencer states (IDLE, PRE, MARK, GAP, RUN, DONE)
//   PAT_SEL_*       : payload pattern encodings carried on PAT_SEL
//   PRBS_SEED/TAP_* : PRBS7 (x^7 + x^6 + 1) seed and feedback tap positions
//   prbs7_step()    : one LFSR advance, output bit is taken from bit 6 first
// ----------------------------------------------------------------------------
package ls_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_MARK = 3'd2,
      ST_GAP  = 3'd3,
      ST_RUN  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [1:0] PAT_SEL_CHECKER = 2'd0;
   localparam logic [1:0] PAT_SEL_ONES    = 2'd1;
   localparam logic [1:0] PAT_SEL_PRBS7   = 2'd2;
   localparam logic [1:0] PAT_SEL_USER    = 2'd3;

   localparam logic [6:0] PRBS_SEED  = 7'h7F;
   localparam int         PRBS_TAP_A = 6;
   localparam int         PRBS_TAP_B = 5;

   function automatic logic [6:0] prbs7_step(input logic [6:0] s);
      return {s[5:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
   endfunction

endpackage

// File: rtl/ls_data_gen_if.sv
// ----------------------------------------------------------------------------
// ls_data_gen_if
// Control/status bundle between the host register block and ls_data_gen.
//   START, ABORT, PAT_SEL, PAT_WORD, NUM_BITS, INJ : host -> generator
//   D_OUT, DATA, BUSY, DONE, BIT_CNT               : generator -> host/pad
// modport master : host side, slave : generator side.
// ----------------------------------------------------------------------------
interface ls_data_gen_if #(
   parameter int CNT_W = 16
);
   logic             START;
   logic             ABORT;
   logic [1:0]       PAT_SEL;
   logic [15:0]      PAT_WORD;
   logic [CNT_W-1:0] NUM_BITS;
   logic             INJ;
   logic             D_OUT;
   logic             DATA;
   logic             BUSY;
   logic             DONE;
   logic [CNT_W-1:0] BIT_CNT;

   modport master (
      output START, ABORT, PAT_SEL, PAT_WORD, NUM_BITS, INJ,
      input  D_OUT, DATA, BUSY, DONE, BIT_CNT
   );

   modport slave (
      input  START, ABORT, PAT_SEL, PAT_WORD, NUM_BITS, INJ,
      output D_OUT, DATA, BUSY, DONE, BIT_CNT
   );
endinterface

// File: rtl/ls_prbs7.sv
// ----------------------------------------------------------------------------
// ls_prbs7
// 7-bit Fibonacci LFSR, polynomial x^7 + x^6 + 1.
//   clk     : clock
//   srst    : synchronous active-high reset, loads the seed
//   load    : reload seed (start of a frame)
//   adv     : advance one step after the current bit has been used
//   bit_out : current output bit (lfsr[6])
// ----------------------------------------------------------------------------
module ls_prbs7
   import ls_test_pkg::*;
(
   input  logic clk,
   input  logic srst,
   input  logic load,
   input  logic adv,
   output logic bit_out
);

   logic [6:0] lfsr_reg;

   always_ff @(posedge clk) begin
      if (srst || load) begin
         lfsr_reg <= PRBS_SEED;
      end else if (adv) begin
         lfsr_reg <= prbs7_step(lfsr_reg);
      end
   end

   assign bit_out = lfsr_reg[PRBS_TAP_A];

endmodule

// File: rtl/ls_data_gen.sv
// ----------------------------------------------------------------------------
// ls_data_gen
// Framed stimulus source for the latch/shift test chip. Each frame on D_OUT is
// PRE_LEN low cycles, one high sync mark, GAP_LEN low cycles, then NUM_BITS
// payload bits (NUM_BITS = 0: continuous until ABORT). DATA is D_OUT delayed
// by CHIP_LAT cycles and is the reference for the Q/DATA checker.
//   CLK  : clock
//   RST  : synchronous active-high reset
//   bus  : ls_data_gen_if.slave
//          START/ABORT control, PAT_SEL/PAT_WORD pattern (held per frame),
//          NUM_BITS length, INJ error inject, D_OUT pad drive, DATA reference,
//          BUSY/DONE status, BIT_CNT payload bits sent (saturating).
// Optional build macro LS_DATA_GEN_ERR_INJ_EN: a rising edge on INJ inverts
// one payload bit on D_OUT only (DATA stays clean); without it INJ is ignored.
// ----------------------------------------------------------------------------
module ls_data_gen
   import ls_test_pkg::*;
#(
   parameter int PRE_LEN  = 8,
   parameter int GAP_LEN  = 4,
   parameter int CHIP_LAT = 2,
   parameter int CNT_W    = 16
)(
   input  logic          CLK,
   input  logic          RST,
   ls_data_gen_if.slave  bus
);

   localparam int LEN_MAX = (PRE_LEN > GAP_LEN) ? PRE_LEN : GAP_LEN;
   localparam int TMR_W   = $clog2(LEN_MAX + 1);
   localparam logic [TMR_W-1:0] PRE_LAST = TMR_W'(PRE_LEN - 1);
   localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_LEN - 1);

   state_t           state_reg, state_next;
   logic [TMR_W-1:0] tmr_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [3:0]       idx_reg;
   logic [1:0]       pat_sel_reg;
   logic [15:0]      pat_word_reg;
   logic             d_clean_reg, d_clean_next;
   logic             busy, done, frame_start, run_step, run_last;
   logic             payload_bit, prbs_bit;

   // Last payload bit: the count after this cycle reaches NUM_BITS.
   assign run_last = (bus.NUM_BITS != '0) &&
                     (({1'b0, cnt_reg} + 1'b1) >= {1'b0, bus.NUM_BITS});

   // ---- state register ----------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---- next-state logic --------------------------------------------------
   always_comb begin
      state_next = state_reg;
      if (bus.ABORT) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: if (bus.START) state_next = ST_PRE;
            ST_PRE:           if (tmr_reg == PRE_LAST) state_next = ST_MARK;
            ST_MARK:          state_next = ST_GAP;
            ST_GAP:           if (tmr_reg == GAP_LAST) state_next = ST_RUN;
            ST_RUN:           if (run_last) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
         endcase
      end
   end

   // ---- payload selection -------------------------------------------------
   // idx_reg starts at 15 and counts down, so its LSB doubles as the
   // checkerboard phase (1 first) and keeps alternating through wraps.
   always_comb begin
      payload_bit = 1'b0;
      case (pat_sel_reg)
         PAT_SEL_CHECKER: payload_bit = idx_reg[0];
         PAT_SEL_ONES:    payload_bit = 1'b1;
         PAT_SEL_PRBS7:   payload_bit = prbs_bit;
         PAT_SEL_USER:    payload_bit = pat_word_reg[idx_reg];
      endcase
   end

   // ---- output / control decode -------------------------------------------
   always_comb begin
      busy         = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
      done         = (state_reg == ST_DONE);
      frame_start  = (state_next == ST_PRE) && (state_reg != ST_PRE);
      run_step     = (state_reg == ST_RUN) && !bus.ABORT;
      d_clean_next = 1'b0;
      if (!bus.ABORT) begin
         if (state_reg == ST_MARK) d_clean_next = 1'b1;
         else if (state_reg == ST_RUN) d_clean_next = payload_bit;
      end
   end

   // ---- datapath registers ------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         tmr_reg      <= '0;
         cnt_reg      <= '0;
         idx_reg      <= 4'd15;
         pat_sel_reg  <= PAT_SEL_CHECKER;
         pat_word_reg <= '0;
         d_clean_reg  <= 1'b0;
      end else begin
         // Dwell timer restarts on every state change.
         if ((state_next != state_reg) ||
             !((state_reg == ST_PRE) || (state_reg == ST_GAP))) begin
            tmr_reg <= '0;
         end else begin
            tmr_reg <= tmr_reg + 1'b1;
         end

         if (frame_start) begin
            cnt_reg      <= '0;
            idx_reg      <= 4'd15;
            pat_sel_reg  <= bus.PAT_SEL;
            pat_word_reg <= bus.PAT_WORD;
         end else if (run_step) begin
            idx_reg <= idx_reg - 4'd1;
            if (cnt_reg != {CNT_W{1'b1}}) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end

         d_clean_reg <= d_clean_next;
      end
   end

   ls_prbs7 u_prbs (
      .clk     (CLK),
      .srst    (RST),
      .load    (frame_start),
      .adv     (run_step),
      .bit_out (prbs_bit)
   );

   // ---- DATA delay line (fed from the uncorrupted stream) -----------------
   logic [CHIP_LAT-1:0] dly_reg, dly_next;

   assign dly_next[0] = d_clean_reg;
   generate
      for (genvar gi = 1; gi < CHIP_LAT; gi++) begin : g_dly
         assign dly_next[gi] = dly_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         dly_reg <= '0;
      end else begin
         dly_reg <= dly_next;
      end
   end

   // ---- optional error injection ------------------------------------------
`ifdef LS_DATA_GEN_ERR_INJ_EN
   logic inj_prev_reg, inj_pend_reg, inv_reg;
   logic inj_now;

   // A rising edge is remembered until it is spent on one RUN bit.
   assign inj_now = inj_pend_reg | (bus.INJ & ~inj_prev_reg);

   always_ff @(posedge CLK) begin
      if (RST) begin
         inj_prev_reg <= 1'b0;
         inj_pend_reg <= 1'b0;
         inv_reg      <= 1'b0;
      end else begin
         inj_prev_reg <= bus.INJ;
         inj_pend_reg <= inj_now & ~run_step;
         inv_reg      <= inj_now & run_step;
      end
   end

   assign bus.D_OUT = d_clean_reg ^ inv_reg;
`else
   logic inj_unused;
   assign inj_unused = bus.INJ;
   assign bus.D_OUT  = d_clean_reg;
`endif

   assign bus.DATA    = dly_reg[CHIP_LAT-1];
   assign bus.BUSY    = busy;
   assign bus.DONE    = done;
   assign bus.BIT_CNT = cnt_reg;

endmodule

// File: tb/tb_ls_data_gen.sv
// ----------------------------------------------------------------------------
// tb_ls_data_gen
// Self-checking bench for ls_data_gen: a frame-level reference model (position
// within the frame -> expected bit) checked every cycle, directed frames with
// literal expectations, then randomized control traffic.
// ----------------------------------------------------------------------------
module tb_ls_data_gen;

   localparam int PRE_LEN  = 8;
   localparam int GAP_LEN  = 4;
   localparam int CHIP_LAT = 2;
   localparam int CNT_W    = 16;
   localparam int P0       = PRE_LEN + GAP_LEN + 2;   // frame offset of payload bit 0

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   ls_data_gen_if #(.CNT_W(CNT_W)) bus ();

   ls_data_gen #(
      .PRE_LEN  (PRE_LEN),
      .GAP_LEN  (GAP_LEN),
      .CHIP_LAT (CHIP_LAT),
      .CNT_W    (CNT_W)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_FRAME, M_DONE} mmode_t;

   mmode_t      m_mode = M_IDLE;
   int          m_k, m_n;
   logic [1:0]  m_sel;
   logic [15:0] m_word;
   bit          exp_clean, exp_dout, exp_data, exp_busy, exp_done;
   int          exp_cnt;
   bit          hist[$];
   bit          model_valid = 1'b0;
   bit          prbs_seq[127];
   bit          m_inj_prev, m_pend;

   initial begin : prbs_init
      logic [6:0] s;
      s = 7'h7F;
      for (int i = 0; i < 127; i++) begin
         prbs_seq[i] = s[6];
         s = {s[5:0], s[6] ^ s[5]};
      end
   end

   function automatic bit payload(input int i, input logic [1:0] sel, input logic [15:0] w);
      case (sel)
         2'd0:    return (i % 2) == 0;
         2'd1:    return 1'b1;
         2'd2:    return prbs_seq[i % 127];
         default: return w[15 - (i % 16)];
      endcase
   endfunction

   // Expected clean stream value k edges after the frame was accepted.
   function automatic bit frame_bit(input int k, input logic [1:0] sel, input logic [15:0] w);
      if (k == PRE_LEN + 1) return 1'b1;
      if (k < P0)           return 1'b0;
      return payload(k - P0, sel, w);
   endfunction

   always @(posedge CLK) begin : model
      bit inv, run_step;
      inv      = 1'b0;
      run_step = 1'b0;
      if (RST) begin
         m_mode     = M_IDLE;
         exp_clean  = 1'b0;
         exp_dout   = 1'b0;
         exp_data   = 1'b0;
         exp_cnt    = 0;
         m_inj_prev = 1'b0;
         m_pend     = 1'b0;
         hist       = {};
         for (int i = 0; i < CHIP_LAT; i++) hist.push_back(1'b0);
         model_valid = 1'b1;
      end else begin
         if (bus.ABORT) begin
            m_mode    = M_IDLE;
            exp_clean = 1'b0;
         end else if (m_mode != M_FRAME && bus.START) begin
            m_mode    = M_FRAME;
            m_k       = 0;
            m_sel     = bus.PAT_SEL;
            m_word    = bus.PAT_WORD;
            m_n       = int'(bus.NUM_BITS);
            exp_cnt   = 0;
            exp_clean = 1'b0;
         end else if (m_mode == M_FRAME) begin
            m_k++;
            exp_clean = frame_bit(m_k, m_sel, m_word);
            if (m_k >= P0) begin
               run_step = 1'b1;
               if (exp_cnt < 65535) exp_cnt++;
            end
            if (m_n != 0 && m_k == P0 - 1 + m_n) m_mode = M_DONE;
         end else begin
            exp_clean = 1'b0;
         end
`ifdef LS_DATA_GEN_ERR_INJ_EN
         begin
            bit now_inj;
            now_inj = m_pend || (bus.INJ && !m_inj_prev);
            inv     = run_step && now_inj;
            m_pend  = now_inj && !run_step;
         end
`endif
         m_inj_prev = bus.INJ;
         exp_dout   = exp_clean ^ inv;
         exp_data   = hist.pop_front();
         hist.push_back(exp_clean);
      end
      exp_busy = (m_mode == M_FRAME);
      exp_done = (m_mode == M_DONE);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin
      if (model_valid) begin
         check("d_out",   32'(bus.D_OUT),   32'(exp_dout));
         check("data",    32'(bus.DATA),    32'(exp_data));
         check("busy",    32'(bus.BUSY),    32'(exp_busy));
         check("done",    32'(bus.DONE),    32'(exp_done));
         check("bit_cnt", 32'(bus.BIT_CNT), exp_cnt);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_frame(input logic [1:0] sel, input logic [15:0] w, input int n);
      bus.PAT_SEL  = sel;
      bus.PAT_WORD = w;
      bus.NUM_BITS = n[CNT_W-1:0];
      bus.START    = 1'b1;
      @(negedge CLK);
      bus.START    = 1'b0;
      // Changing these after acceptance must not disturb the frame.
      bus.PAT_SEL  = ~sel;
      bus.PAT_WORD = ~w;
   endtask

   task automatic collect(input int n, output logic [63:0] vd, output logic [63:0] vq);
      vd = '0;
      vq = '0;
      for (int i = 0; i < n; i++) begin
         vd = {vd[62:0], bus.D_OUT};
         vq = {vq[62:0], bus.DATA};
         if (i < n - 1) @(negedge CLK);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- directed + random stimulus ----------------
   initial begin : driver
      logic [63:0] vd, vq;
      bus.START    = 1'b0;
      bus.ABORT    = 1'b0;
      bus.PAT_SEL  = 2'd0;
      bus.PAT_WORD = 16'h0;
      bus.NUM_BITS = '0;
      bus.INJ      = 1'b0;
      RST          = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_d_out", 32'(bus.D_OUT),   32'd0);
      check("rst_data",  32'(bus.DATA),    32'd0);
      check("rst_busy",  32'(bus.BUSY),    32'd0);
      check("rst_cnt",   32'(bus.BIT_CNT), 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      // Checkerboard, 6 bits: 9 idle/pre zeros, mark, 4 gap zeros, 101010.
      start_frame(2'd0, 16'h0, 6);
      collect(20, vd, vq);
      check("cb_stream", vd[31:0], 32'h0042A);
      check("cb_delay",  vq[31:0], 32'h0010A);
      check("cb_done",   32'(bus.DONE),    32'd1);
      check("cb_cnt",    32'(bus.BIT_CNT), 32'd6);

      // PRBS7, 8 bits, twice from the same seed.
      for (int r = 0; r < 2; r++) begin
         start_frame(2'd2, 16'h0, 8);
         collect(22, vd, vq);
         check("prbs_payload", 32'(vd[7:0]), 32'hFE);
         check("prbs_cnt",     32'(bus.BIT_CNT), 32'd8);
      end

      // User word, 20 bits: A5C3 then the first four bits again.
      start_frame(2'd3, 16'hA5C3, 20);
      collect(34, vd, vq);
      check("word_payload", 32'(vd[19:0]), 32'hA5C3A);

      // Continuous mode, stray START mid-run, ABORT at bit 100.
      start_frame(2'd0, 16'h0, 0);
      for (int i = 0; i < 400; i++) begin
         if (bus.BIT_CNT == 16'd100) break;
         bus.START = (bus.BIT_CNT == 16'd50);
         @(negedge CLK);
      end
      bus.START = 1'b0;
      check("cont_reach_100", 32'(bus.BIT_CNT), 32'd100);
      bus.ABORT = 1'b1;
      @(negedge CLK);
      bus.ABORT = 1'b0;
      check("abort_busy",  32'(bus.BUSY),    32'd0);
      check("abort_d_out", 32'(bus.D_OUT),   32'd0);
      check("abort_cnt",   32'(bus.BIT_CNT), 32'd100);
      repeat (3) @(negedge CLK);

      // Reset in the middle of an all-ones run.
      start_frame(2'd1, 16'h0, 0);
      repeat (20) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check("mid_rst_d_out", 32'(bus.D_OUT),   32'd0);
      check("mid_rst_data",  32'(bus.DATA),    32'd0);
      check("mid_rst_cnt",   32'(bus.BIT_CNT), 32'd0);
      check("mid_rst_busy",  32'(bus.BUSY),    32'd0);
      RST = 1'b0;
      @(negedge CLK);

`ifdef LS_DATA_GEN_ERR_INJ_EN
      // INJ pulse lands on payload bit 3 of an all-ones frame.
      start_frame(2'd1, 16'h0, 8);
      repeat (P0 + 2) @(negedge CLK);
      bus.INJ = 1'b1;
      @(negedge CLK);
      bus.INJ = 1'b0;
      check("inj_d_out_bit3", 32'(bus.D_OUT), 32'd0);
      @(negedge CLK);
      check("inj_d_out_bit4", 32'(bus.D_OUT), 32'd1);
      @(negedge CLK);
      check("inj_data_bit3",  32'(bus.DATA),  32'd1);
      repeat (6) @(negedge CLK);
`endif

      // Randomized control traffic.
      for (int c = 0; c < 700; c++) begin
         bus.START    = ($urandom_range(3) == 0);
         bus.ABORT    = ($urandom_range(59) == 0);
         bus.INJ      = 1'($urandom_range(1));
         RST          = ($urandom_range(249) == 0);
         bus.PAT_SEL  = 2'($urandom_range(3));
         bus.PAT_WORD = 16'($urandom);
         if (m_mode != M_FRAME)
            bus.NUM_BITS = ($urandom_range(4) == 0) ? '0 : CNT_W'($urandom_range(30, 1));
         @(negedge CLK);
      end
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      bus.INJ   = 1'b0;
      RST       = 1'b0;
      repeat (4) @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ls_data_gen.md
Name: ls_data_gen

Overview:
- Stimulus source for the latch/shift test chip; the transmit end of the Q/DATA compare path.
- Drives `D_OUT` into the chip as a framed stream: low preamble, single-cycle high sync mark, low gap, then NUM_BITS of the selected pattern.
- Drives `DATA`, a copy of the stream delayed by CHIP_LAT cycles, which the downstream checker compares against the chip's Q.
- Sits between host/UART control registers and the test-chip pad.

Parameters:
- PRE_LEN, 8, cycles of forced-low preamble before the sync mark (>=1).
- GAP_LEN, 4, low cycles between sync mark and first payload bit (>=1).
- CHIP_LAT, 2, pipeline depth of the `DATA` delay line; matches chip D->Q latency (1..15).
- CNT_W, 16, width of bit counter and NUM_BITS.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- START  in  1  one-cycle pulse; begins a frame when idle.
- ABORT  in  1  returns to IDLE on the next edge.
- PAT_SEL  in  2  payload type: 0 checkerboard, 1 all-ones, 2 PRBS7, 3 user word.
- PAT_WORD  in  16  user word; sent MSB first and repeated.
- NUM_BITS  in  CNT_W  payload length; 0 means continuous until ABORT.
- INJ  in  1  error-inject request (see optional feature).
- D_OUT  out  1  registered drive to test-chip input.
- DATA  out  1  `D_OUT` delayed CHIP_LAT cycles; reference for the checker.
- BUSY  out  1  high in any state except IDLE/DONE.
- DONE  out  1  high in DONE.
- BIT_CNT  out  CNT_W  payload bits sent in the current frame.

Behaviour:
- Reset: state=IDLE. `D_OUT`, `DATA`, the whole delay line, `BUSY`, `DONE` = 0; `BIT_CNT` = 0; PRBS register = 7'h7F; word index = 15.
- FSM states: IDLE, PRE, MARK, GAP, RUN, DONE.
  - IDLE: START=1 -> PRE.
  - PRE: PRE_LEN cycles -> MARK.
  - MARK: 1 cycle -> GAP.
  - GAP: GAP_LEN cycles -> RUN.
  - RUN: NUM_BITS cycles, or forever if NUM_BITS=0 -> DONE.
  - DONE: START=1 -> PRE (restart); else hold.
- Frame timing:
  - `D_OUT` is 0 in PRE/GAP/IDLE/DONE and 1 in MARK.
  - `D_OUT` is registered: the value for state S appears the cycle after S is entered.
  - `D_OUT` is high for exactly one cycle before the payload, so the checker's rising-edge detector fires once.
- ABORT: in any state, next edge -> IDLE. `D_OUT` goes 0 and `BIT_CNT` holds. Higher priority than START.
- START while BUSY: ignored.
- Payload, one bit per cycle in RUN:
  - PAT_SEL=0: alternates 1,0,1,0..., starting with 1.
  - PAT_SEL=1: constant 1.
  - PAT_SEL=2: PRBS7 x^7+x^6+1. Output bit = lfsr[6]; then lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}. Seed 7'h7F reloaded on entry to PRE.
  - PAT_SEL=3: PAT_WORD[idx]; idx counts 15 down to 0 and wraps.
  - PAT_SEL and PAT_WORD are sampled on entry to PRE and held for the frame.
- Counter:
  - `BIT_CNT` is cleared on entry to PRE.
  - Increments once per RUN cycle, saturating at all-ones.
  - In continuous mode it saturates; the stream continues.
- Delay line: CHIP_LAT-deep shift register of `D_OUT`.
  - `DATA(t) = D_OUT(t-CHIP_LAT)`.
  - Not cleared by ABORT; it drains naturally.

Optional Feature:
- Macro: LS_DATA_GEN_ERR_INJ_EN.
- Enabled: INJ=1 in RUN inverts the next payload bit on `D_OUT` only; `DATA` carries the uninverted bit.
  - Exactly one bit is corrupted per INJ rising edge.
  - An INJ rising edge outside RUN is held pending until the first RUN bit.
- Disabled: INJ is ignored, and `DATA` always equals delayed `D_OUT`.

Decomposition:
- Shared package `ls_test_pkg` holds:
  - the state enum (IDLE..DONE);
  - the PAT_SEL encodings;
  - PRBS7 seed 7'h7F and tap positions.
- One natural sub-module, `ls_prbs7`: 7-bit LFSR with load/advance enables and 1-bit output.

Test Plan:
- PAT_SEL=0, NUM_BITS=6, defaults, START pulse:
  - `D_OUT` is 8x0, 1x1, 4x0, then 1,0,1,0,1,0.
  - DONE high after the 6th bit; `BIT_CNT`=6.
  - `DATA` equals `D_OUT` delayed 2 cycles.
- PAT_SEL=2, NUM_BITS=8 -> payload 1,1,1,1,1,1,1,0. Second frame restarts from the same seed.
- PAT_SEL=3, PAT_WORD=16'hA5C3, NUM_BITS=20 -> A5C3 MSB-first, then 1,0,1,0.
- NUM_BITS=0, ABORT at payload bit 100 -> IDLE next edge, `D_OUT`=0, `BIT_CNT`=100, BUSY=0.
- START during RUN ignored. RST asserted mid-RUN -> all outputs 0 on the next edge, delay line included.
- With LS_DATA_GEN_ERR_INJ_EN: INJ pulse at payload bit 3 of all-ones -> `D_OUT` bit 3 = 0 and `DATA` = 1. Paired with the checker, its error count = 1.
